// File: rtl/pt100_uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pt100_uart_pkg
// Brief    : Shared constants, baud increment helper and TX state type for
//            the PT100 ADC serial link.
// Revision : 1.0 - initial release
// ============================================================================
package pt100_uart_pkg;

    localparam int CLK_HZ_DEF    = 50_000_000;
    localparam int BAUD_DEF      = 9600;
    localparam int ACC_WIDTH_DEF = 20;

    // Marks the high byte so the receiver can resynchronise on word order.
    localparam logic MSB_FLAG  = 1'b1;
    localparam int   LSB_WIDTH = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP1 = 3'd3,
        S_STOP2 = 3'd4,
        S_GAP   = 3'd5
    } tx_state_t;

    // round(baud * 2^acc_width / clk_hz)
    function automatic int baud_inc(input int clk_hz, input int baud, input int acc_width);
        longint num;
        num = longint'(baud) * (longint'(1) << acc_width);
        return int'((2 * num + longint'(clk_hz)) / (2 * longint'(clk_hz)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pt100_baud_tick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pt100_baud_tick
// Brief    : Fractional phase accumulator producing a one-cycle baud enable.
// Revision : 1.0 - initial release
// ============================================================================
module pt100_baud_tick
    import pt100_uart_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int BAUD_INC   = 201,
    parameter int OVERSAMPLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [ACC_WIDTH:0] C_INC = (ACC_WIDTH+1)'(BAUD_INC * OVERSAMPLE);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + C_INC;
    // Carry of the pending add is the tick, so the first period after clr is full length.
    assign tick  = w_sum[ACC_WIDTH] & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pt100_adc_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pt100_adc_uart_tx
// Brief    : Sends a 10-bit ADC sample as two 8N2 UART frames, high byte first.
// Revision : 1.0 - initial release
// ============================================================================
module pt100_adc_uart_tx
    import pt100_uart_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEF,
    parameter int BAUD      = BAUD_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int BAUD_INC  = baud_inc(CLK_HZ, BAUD, ACC_WIDTH),
    parameter int GAP_BITS  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sample_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic       C_HAS_GAP  = (GAP_BITS > 0);
    localparam logic [3:0] C_GAP_LAST = 4'(GAP_BITS - 1);

    tx_state_t            r_state;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_byte_idx;
    logic [LSB_WIDTH-1:0] r_lsb;
    logic [3:0]           r_gap_cnt;
    logic                 w_accept;
    logic                 w_tick;

    assign w_accept = (r_state == S_IDLE) && valid_i && ready_o;

    pt100_baud_tick #(
        .ACC_WIDTH  (ACC_WIDTH),
        .BAUD_INC   (BAUD_INC),
        .OVERSAMPLE (1)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= 1'b0;
            r_lsb      <= '0;
            r_gap_cnt  <= '0;
            tx_o       <= 1'b1;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ready_o <= 1'b1;
                    if (w_accept) begin
                        r_shift    <= {MSB_FLAG, sample_i[9:LSB_WIDTH]};
                        r_lsb      <= sample_i[LSB_WIDTH-1:0];
                        r_byte_idx <= 1'b0;
                        ready_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        tx_o       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_bit_cnt <= '0;
                        tx_o      <= r_shift[0];
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 3'd7) begin
                            tx_o    <= 1'b1;
                            r_state <= S_STOP1;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            tx_o      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_STOP1: begin
                    if (w_tick) begin
                        r_state <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (w_tick) begin
                        if (!r_byte_idx) begin
                            r_byte_idx <= 1'b1;
                            r_shift    <= {{(8-LSB_WIDTH){1'b0}}, r_lsb};
                            if (C_HAS_GAP) begin
                                r_gap_cnt <= '0;
                                r_state   <= S_GAP;
                            end else begin
                                tx_o    <= 1'b0;
                                r_state <= S_START;
                            end
                        end else begin
                            done_o  <= 1'b1;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_gap_cnt == C_GAP_LAST) begin
                            tx_o    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_o    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pt100_adc_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pt100_adc_uart_tx
// Brief    : Self-checking bench; a line-level UART model decodes tx_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pt100_adc_uart_tx;

    localparam int     CLK_HZ_T = 1_000_000;
    localparam int     BAUD_T   = 20_000;
    // round(20000 * 2^20 / 1e6)
    localparam longint INC      = 20972;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sample0 = '0, sample1 = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       ready0, tx0, busy0, done0;
    logic       ready1, tx1, busy1, done1;
    bit         sel = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pt100_adc_uart_tx #(
        .CLK_HZ (CLK_HZ_T), .BAUD (BAUD_T), .ACC_WIDTH (20), .GAP_BITS (0)
    ) dut0 (
        .clk (clk), .reset (reset), .sample_i (sample0), .valid_i (valid0),
        .ready_o (ready0), .tx_o (tx0), .busy_o (busy0), .done_o (done0)
    );

    pt100_adc_uart_tx #(
        .CLK_HZ (CLK_HZ_T), .BAUD (BAUD_T), .ACC_WIDTH (20), .GAP_BITS (3)
    ) dut1 (
        .clk (clk), .reset (reset), .sample_i (sample1), .valid_i (valid1),
        .ready_o (ready1), .tx_o (tx1), .busy_o (busy1), .done_o (done1)
    );

    wire w_tx    = sel ? tx1    : tx0;
    wire w_ready = sel ? ready1 : ready0;
    wire w_busy  = sel ? busy1  : busy0;
    wire w_done  = sel ? done1  : done0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clock edge (counted from the accept edge) at which line bit j begins.
    function automatic longint tedge(input int j);
        return (longint'(j) * (longint'(1) << 20) + INC - 1) / INC;
    endfunction

    task automatic set_in(input logic [9:0] s, input logic v);
        if (sel) begin
            sample1 = s;
            valid1  = v;
        end else begin
            sample0 = s;
            valid0  = v;
        end
    endtask

    // Offers one sample, decodes the resulting line and checks bits and timing.
    task automatic frame(input logic [9:0] s, input int g, input bit keep, output int wait_n);
        int          nb;
        int          n;
        int          first_hi;
        int          fr;
        int          done_at;
        logic [7:0]  b0, b1, rx0, rx1;
        logic [63:0] exp_line, got_line;
        nb       = 22 + g;
        b0       = {1'b1, s[9:3]};
        b1       = {5'b00000, s[2:0]};
        exp_line = '1;
        got_line = '1;
        exp_line[0] = 1'b0;
        exp_line[11+g] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_line[1+i]    = b0[i];
            exp_line[12+g+i] = b1[i];
        end
        fr = 0;
        while (exp_line[fr] == 1'b0) fr++;

        set_in(s, 1'b1);
        wait_n = 0;
        while (!w_ready) begin
            @(negedge clk);
            wait_n++;
            if (wait_n > 500) begin
                chk("accept_timeout", 64'd1, 64'd0);
                set_in(s, 1'b0);
                return;
            end
        end

        n        = 0;
        first_hi = -1;
        done_at  = -1;
        while (done_at < 0 && n < tedge(nb) + 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("tx_low_after_accept", 64'(w_tx), 64'd0);
                chk("busy_after_accept", 64'(w_busy), 64'd1);
                chk("ready_after_accept", 64'(w_ready), 64'd0);
                chk("done_single_cycle", 64'(w_done), 64'd0);
                set_in(10'($urandom), keep);
            end
            if (first_hi < 0 && w_tx) first_hi = n - 1;
            if (w_done) done_at = n - 1;
            for (int j = 0; j < nb; j++) begin
                if (longint'(n) == (tedge(j) + tedge(j+1)) / 2 + 1) got_line[j] = w_tx;
            end
        end

        for (int i = 0; i < 8; i++) begin
            rx0[i] = got_line[1+i];
            rx1[i] = got_line[12+g+i];
        end
        chk("first_rise_time", 64'(first_hi), 64'(tedge(fr)));
        chk("done_time", 64'(done_at), 64'(tedge(nb)));
        chk("line_bits", got_line, exp_line);
        chk("byte0", 64'(rx0), 64'(b0));
        chk("byte1", 64'(rx1), 64'(b1));
        chk("rx_adc", 64'({rx0[6:0], rx1[2:0]}), 64'(s));
        chk("ready_at_done", 64'(w_ready), 64'd1);
        chk("busy_at_done", 64'(w_busy), 64'd0);
    endtask

    initial begin
        int     w;
        int     guard;
        longint mid;

        // Reset behaviour
        repeat (5) @(negedge clk);
        chk("rst_tx", 64'(tx0), 64'd1);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_ready", 64'(ready0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        reset = 1'b0;
        chk("ready_before_edge", 64'(ready0), 64'd0);
        @(negedge clk);
        chk("ready_after_release", 64'(ready0), 64'd1);
        chk("ready1_after_release", 64'(ready1), 64'd1);
        repeat (5) @(negedge clk);
        chk("idle_tx_high", 64'(tx0), 64'd1);

        // Encoding and timing
        frame(10'h2A5, 0, 1'b0, w);
        repeat (3) @(negedge clk);
        frame(10'h155, 0, 1'b0, w);
        repeat (3) @(negedge clk);
        sel = 1'b1;
        frame(10'h155, 3, 1'b0, w);
        repeat (3) @(negedge clk);
        sel = 1'b0;

        // Boundaries, back-to-back with valid held high
        frame(10'h000, 0, 1'b1, w);
        frame(10'h3FF, 0, 1'b0, w);
        chk("b2b_accept_wait", 64'(w), 64'd0);
        repeat (3) @(negedge clk);

        // Reset during byte0 data bit 3
        set_in(10'h2A5, 1'b1);
        guard = 0;
        while (!ready0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_accept_ready", 64'(ready0), 64'd1);
        @(negedge clk);
        valid0 = 1'b0;
        mid = (tedge(4) + tedge(5)) / 2 + 1;
        repeat (int'(mid) - 1) @(negedge clk);
        chk("pre_reset_bit3", 64'(tx0), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", 64'(tx0), 64'd1);
        chk("async_reset_busy", 64'(busy0), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_reset", 64'(ready0), 64'd1);
        chk("tx_after_mid_reset", 64'(tx0), 64'd1);
        frame(10'h2A5, 0, 1'b0, w);

        // Receiver loopback, including random samples
        repeat (2) @(negedge clk);
        frame(10'h000, 0, 1'b0, w);
        frame(10'h2A5, 0, 1'b0, w);
        frame(10'h3FF, 0, 1'b0, w);
        for (int k = 0; k < 4; k++) begin
            repeat (1 + ($urandom % 4)) @(negedge clk);
            frame(10'($urandom), 0, 1'b0, w);
        end
        sel = 1'b1;
        frame(10'($urandom), 3, 1'b0, w);
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
